rate_encoding_mul_pipe: RTL and testbench
=========================================

# rate_encoding_mul_pipe

Parametrised, pipelined integer multiplier for the SNN rate-encoding datapath. Successor to the fixed-width combinational multiply: configurable operand/result widths, NUM_STAGE latency, per-transaction signed/unsigned mode, valid/ready flow control with full-pipeline stall, overflow detection and a saturating overflow event counter. Sits between pixel-intensity scaling and the spike-threshold comparator.

## Interface

- ID, 1: instance tag, no functional effect
- NUM_STAGE, 2: register stages from input to output, legal 1..4
- din0_WIDTH, 5: operand A width
- din1_WIDTH, 11: operand B width
- dout_WIDTH, 15: result width, legal 2..din0_WIDTH+din1_WIDTH
- CNT_WIDTH, 16: overflow counter width
- ap_clk  in  1: clock, rising edge
- ap_rst_n  in  1: asynchronous reset, active low
- in_valid  in  1: operands valid
- in_ready  out  1: block accepts operands this cycle
- din0  in  din0_WIDTH: operand A
- din1  in  din1_WIDTH: operand B
- signed_mode  in  1: 1 = both operands two's complement, 0 = both unsigned; sampled with operands
- out_valid  out  1: result valid
- out_ready  in  1: downstream accepts result
- dout  out  dout_WIDTH: result
- ovf  out  1: true product did not fit dout_WIDTH in the selected mode; qualified by out_valid
- ovf_cnt  out  CNT_WIDTH: count of delivered results with ovf=1, saturates at all-ones
- cnt_clr  in  1: synchronous clear of ovf_cnt

## Operation

- Accept: in_valid && in_ready. Stage 1 captures din0, din1, signed_mode, valid=1.
- Full product P, width din0_WIDTH+din1_WIDTH+1: operands sign-extended (signed_mode=1) or zero-extended (0), then signed multiply; exact, never wraps.
- Product and ovf computed from stage-1 registers; stages 2..NUM_STAGE delay {valid, result, ovf} unchanged.
- Overflow: unsigned mode, any P bit at or above dout_WIDTH set; signed mode, P outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
- dout default: low dout_WIDTH bits of P (wrap), see Configuration.
- Flow control: advance = !out_valid || out_ready; in_ready = advance. advance=0 freezes every stage (data and valid). advance=1 shifts all stages; empty stages shift as bubbles.
- Deliver: out_valid && out_ready. On deliver with ovf=1, ovf_cnt increments unless all-ones.
- cnt_clr and an overflow deliver in the same cycle: counter becomes 0 (clear wins).
- signed_mode travels with its operands; mixing modes back-to-back is legal.

## Timing

- Reset (ap_rst_n=0, asynchronous): all stage valids 0, all data registers 0, out_valid=0, dout=0, ovf=0, ovf_cnt=0. in_ready=1 immediately after deassertion.
- Reset mid-operation discards in-flight results; nothing delivered for them.
- Latency: operand accepted on edge k gives out_valid=1 after edge k+NUM_STAGE-1 (NUM_STAGE=1: visible right after the accept edge).
- Throughput: one result per cycle while out_ready=1.
- Stall: outputs stable while out_valid && !out_ready; no loss, no duplication.
- in_ready is combinational from out_valid and out_ready; no other comb path input to output.

## Configuration

- RATE_ENC_MUL_SAT_EN defined: when ovf=1, dout clamps to mode limit: unsigned 2^dout_WIDTH-1; signed max 2^(dout_WIDTH-1)-1 or min -2^(dout_WIDTH-1) by sign of P.
- Undefined: dout is low dout_WIDTH bits of P (wrap). ovf and ovf_cnt identical in both builds.

## Test plan

- Defaults, unsigned 5*100, out_ready=1 -> dout=500, ovf=0, out_valid exactly 1 cycle after accept edge (NUM_STAGE=2).
- Unsigned 31*2047 -> P=63457, ovf=1; dout=30689 without macro, 32767 with; ovf_cnt=1.
- Signed -16 * -1024 -> P=16384, ovf=1; dout=0x4000 without macro, 16383 with; signed -16*1023 -> -16368, ovf=0.
- Stream 8 back-to-back inputs, out_ready low cycles 3-5 -> in_ready low while output blocked, all 8 results delivered in order, no drops/duplicates.
- 65537 overflowing results with CNT_WIDTH=16 -> ovf_cnt sticks at 65535; cnt_clr asserted with an overflow deliver -> ovf_cnt=0.
- ap_rst_n pulsed low with 2 results in flight -> out_valid=0, dout=0, ovf_cnt=0 asynchronously; no stale result after release.

Source files
------------

// File: rtl/rate_encoding_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier with valid/ready flow control,
// overflow flag and saturating overflow counter. Define RATE_ENC_MUL_SAT_EN to clamp dout on overflow.
module rate_encoding_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 5,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  input  logic                  cnt_clr
);

  // One extra bit lets an unsigned product be treated as a non-negative signed value.
  localparam int PW = din0_WIDTH + din1_WIDTH + 1;

  if (NUM_STAGE < 1 || NUM_STAGE > 4 || dout_WIDTH < 2 ||
      dout_WIDTH > din0_WIDTH + din1_WIDTH || CNT_WIDTH < 1 || ID < 0) begin : g_param_check
    $error("rate_encoding_mul_pipe: illegal parameter combination");
  end

  logic                  advance;
  logic                  deliver;
  logic                  s1_valid;
  logic                  s1_mode;
  logic [din0_WIDTH-1:0] s1_a;
  logic [din1_WIDTH-1:0] s1_b;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign deliver  = out_valid && out_ready;

  // NOTE: every register, including the data stages, is reset so the outputs read 0 after reset,
  // and all sequential state uses non-blocking assignments so stages shift in lock-step.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= signed_mode;
        s1_a    <= din0;
        s1_b    <= din1;
      end
    end
  end

  logic signed [PW-1:0]  ext_a;
  logic signed [PW-1:0]  ext_b;
  logic signed [PW-1:0]  prod;
  logic                  prod_ovf;
  logic [dout_WIDTH-1:0] prod_res;

  assign ext_a = {{(PW-din0_WIDTH){s1_mode & s1_a[din0_WIDTH-1]}}, s1_a};
  assign ext_b = {{(PW-din1_WIDTH){s1_mode & s1_b[din1_WIDTH-1]}}, s1_b};
  assign prod  = ext_a * ext_b;

  // Signed fit: all bits from the result sign bit upward agree.
  always_comb begin
    if (s1_mode) begin
      prod_ovf = !((&prod[PW-1:dout_WIDTH-1]) || !(|prod[PW-1:dout_WIDTH-1]));
    end else begin
      prod_ovf = |prod[PW-1:dout_WIDTH];
    end
  end

`ifdef RATE_ENC_MUL_SAT_EN
  logic [dout_WIDTH-1:0] sat_val;

  always_comb begin
    if (!s1_mode) begin
      sat_val = '1;
    end else if (prod[PW-1]) begin
      sat_val = {1'b1, {(dout_WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(dout_WIDTH-1){1'b1}}};
    end
  end

  assign prod_res = prod_ovf ? sat_val : prod[dout_WIDTH-1:0];
`else
  assign prod_res = prod[dout_WIDTH-1:0];
`endif

  if (NUM_STAGE == 1) begin : g_single
    assign out_valid = s1_valid;
    assign dout      = prod_res;
    assign ovf       = prod_ovf;
  end else begin : g_multi
    logic [NUM_STAGE-2:0]  pv;
    logic [NUM_STAGE-2:0]  po;
    logic [dout_WIDTH-1:0] pr [NUM_STAGE-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        pv <= '0;
        po <= '0;
        for (int i = 0; i < NUM_STAGE-1; i++) pr[i] <= '0;
      end else if (advance) begin
        pv[0] <= s1_valid;
        po[0] <= prod_ovf;
        pr[0] <= prod_res;
        for (int i = 1; i < NUM_STAGE-1; i++) begin
          pv[i] <= pv[i-1];
          po[i] <= po[i-1];
          pr[i] <= pr[i-1];
        end
      end
    end

    assign out_valid = pv[NUM_STAGE-2];
    assign ovf       = po[NUM_STAGE-2];
    assign dout      = pr[NUM_STAGE-2];
  end

  // Clear has priority over a coincident overflow delivery.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (deliver && ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rate_encoding_mul_pipe.sv
// Self-checking bench for rate_encoding_mul_pipe: directed vectors plus randomized
// streams scored against an arithmetic reference model.
module tb_rate_encoding_mul_pipe;

  localparam int NS   = 2;
  localparam int AW   = 5;
  localparam int BW   = 11;
  localparam int OW   = 15;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] din0 = '0;
  logic [BW-1:0] din1 = '0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] dout;
  logic          ovf;
  logic [CW-1:0] ovf_cnt;
  logic          cnt_clr = 1'b0;

  rate_encoding_mul_pipe #(
    .ID(1), .NUM_STAGE(NS), .din0_WIDTH(AW), .din1_WIDTH(BW),
    .dout_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [OW-1:0] d;
    logic          o;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            exp_cnt = 0;
  int            n_deliv = 0;
  logic          held = 1'b0;
  logic [OW-1:0] held_d;
  logic          held_o;
  logic          dmy;

  // Reference: exact integer product, range test against the mode's representable interval.
  function automatic exp_t model(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic m);
    longint va, vb, p, lo, hi;
    longint one = 1;
    exp_t   e;
    va = m ? longint'($signed(a)) : longint'(a);
    vb = m ? longint'($signed(b)) : longint'(b);
    p  = va * vb;
    if (m) begin
      lo = -(one << (OW-1));
      hi = (one << (OW-1)) - 1;
    end else begin
      lo = 0;
      hi = (one << OW) - 1;
    end
    e.o = (p < lo) || (p > hi);
    e.d = OW'(p);
`ifdef RATE_ENC_MUL_SAT_EN
    if (e.o) e.d = (p > hi) ? OW'(hi) : OW'(lo);
`endif
    return e;
  endfunction

  // One clock of stimulus; inputs change at posedge+1, outputs are sampled at negedge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic m, input logic r, input logic c, output logic acc);
    exp_t e;
    logic got_ovf;
    in_valid = v; din0 = a; din1 = b; signed_mode = m; out_ready = r; cnt_clr = c;
    got_ovf = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (in_ready !== (!out_valid || r))
      $display("FAIL in_ready: got %b required %b", in_ready, !out_valid || r);
    if (held) begin
      checks++;
      if (out_valid !== 1'b1 || dout !== held_d || ovf !== held_o) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%0h o=%b required v=1 d=%0h o=%b",
                 out_valid, dout, ovf, held_d, held_o);
      end
    end
    acc = v && in_ready;
    if (acc) sb.push_back(model(a, b, m));
    if (out_valid && r) begin
      checks++;
      n_deliv++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_result: got dout=%0h with nothing expected", dout);
      end else begin
        e = sb.pop_front();
        got_ovf = e.o;
        if (dout !== e.d || ovf !== e.o) begin
          errors++;
          $display("FAIL result: got dout=%0h ovf=%b required dout=%0h ovf=%b",
                   dout, ovf, e.d, e.o);
        end
      end
    end
    if (c) exp_cnt = 0;
    else if (got_ovf && exp_cnt < CMAX) exp_cnt++;
    held   = out_valid && !r;
    held_d = dout;
    held_o = ovf;
    @(posedge ap_clk);
    #1;
    checks++;
    if (ovf_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL ovf_cnt: got %0d required %0d", ovf_cnt, exp_cnt);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, dmy);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || ovf !== 1'b0 || ovf_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%0h o=%b cnt=%0d required all zero",
               out_valid, dout, ovf, ovf_cnt);
    end
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_latency();
    int n = 0;
    in_valid = 1'b1; din0 = 5'd5; din1 = 11'd100; signed_mode = 1'b0; out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    checks++;
    if (n != NS - 1 || dout !== 15'd500 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL latency_5x100: got edges=%0d dout=%0d ovf=%b required edges=%0d dout=500 ovf=0",
               n, dout, ovf, NS - 1);
    end
    @(posedge ap_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle_valid: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic send_one(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic m,
                          input logic [OW-1:0] ed, input logic eo, input string name);
    int n = 0;
    in_valid = 1'b1; din0 = a; din1 = b; signed_mode = m; out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || dout !== ed || ovf !== eo) begin
      errors++;
      $display("FAIL %s: got v=%b dout=%0d ovf=%b required v=1 dout=%0d ovf=%b",
               name, out_valid, dout, ovf, ed, eo);
    end
    @(posedge ap_clk);
    #1;
    if (eo && exp_cnt < CMAX) exp_cnt++;
    checks++;
    if (ovf_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_cnt: got %0d required %0d", name, ovf_cnt, exp_cnt);
    end
  endtask

  task automatic test_known_vectors();
`ifdef RATE_ENC_MUL_SAT_EN
    send_one(5'd31, 11'd2047, 1'b0, 15'd32767, 1'b1, "u_31x2047");
    send_one(5'd16, 11'd1024, 1'b1, 15'd16383, 1'b1, "s_m16xm1024");
`else
    send_one(5'd31, 11'd2047, 1'b0, 15'd30689, 1'b1, "u_31x2047");
    send_one(5'd16, 11'd1024, 1'b1, 15'h4000, 1'b1, "s_m16xm1024");
`endif
    send_one(5'd16, 11'd1023, 1'b1, 15'd16400, 1'b0, "s_m16x1023");
    send_one(5'd31, 11'd1, 1'b1, 15'h7fff, 1'b0, "s_m1x1");
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   base = n_deliv;
    logic acc;
    logic [AW-1:0] a = AW'($urandom);
    logic [BW-1:0] b = BW'($urandom);
    logic          m = 1'($urandom);
    for (int i = 0; i < 16; i++) begin
      step(sent < 8, a, b, m, !(i inside {3, 4, 5}), 1'b0, acc);
      if (acc) begin
        sent++;
        a = AW'($urandom);
        b = BW'($urandom);
        m = 1'($urandom);
      end
    end
    drain();
    checks++;
    if (n_deliv - base != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d delivered required 8", n_deliv - base);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), AW'($urandom), BW'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0), dmy);
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 5'd31, 11'd2047, 1'b0, 1'b1, 1'b0, dmy);
    drain();
    step(1'b1, 5'd31, 11'd2000, 1'b0, 1'b1, 1'b0, dmy);
    step(1'b1, 5'd30, 11'd2047, 1'b0, 1'b1, 1'b0, dmy);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || ovf !== 1'b0 || ovf_cnt !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%0h o=%b cnt=%0d rdy=%b required 0/0/0/0/1",
               out_valid, dout, ovf, ovf_cnt, in_ready);
    end
    sb.delete();
    exp_cnt = 0;
    held = 1'b0;
    in_valid = 1'b0;
    #10;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, dmy);
    step(1'b1, 5'd7, 11'd9, 1'b0, 1'b1, 1'b0, dmy);
    drain();
  endtask

  task automatic test_ovf_saturation();
    int n = 0;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, dmy);
    for (int i = 0; i < 65537; i++) step(1'b1, 5'd31, 11'd2047, 1'b0, 1'b1, 1'b0, dmy);
    drain();
    checks++;
    if (ovf_cnt !== 16'hffff) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d required 65535", ovf_cnt);
    end
    step(1'b1, 5'd16, 11'd1024, 1'b1, 1'b1, 1'b0, dmy);
    while (!out_valid && n < 10) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, dmy);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got v=%b ovf=%b required v=1 ovf=1", out_valid, ovf);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, dmy);
    checks++;
    if (ovf_cnt !== '0) begin
      errors++;
      $display("FAIL clr_wins: got %0d required 0", ovf_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_known_vectors();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_ovf_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
